ap_param: RTL and testbench

AP_PARAM -- requirements
Module: ap_param

---
 rtl/ap_param_if.sv | 28 ++
 rtl/ap_param.sv | 144 ++++++++++++++
 tb/tb_ap_param.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ap_param_if.sv
// Host-side bus of the ap_param associative bit-serial processor.
// start is a level sampled only while idle; done is a one-cycle completion pulse (the interrupt).
interface ap_param_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [1:0]        op;
  logic              write_en;
  logic              sel_col;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  data;
  logic [WIDTH-1:0]  data_out;
  logic              busy;
  logic              done;
  logic              err;
  logic [2:0]        dbg_state;

  modport master (
    output start, op, write_en, sel_col, addr, data,
    input  data_out, busy, done, err, dbg_state
  );

  modport slave (
    input  start, op, write_en, sel_col, addr, data,
    output data_out, busy, done, err, dbg_state
  );
endinterface

// File: rtl/ap_param.sv
// Associative processor: two word columns processed bit-serially, LSB first, by compare/write passes
// applied to every row in parallel. B <= A op B for OR, AND and ADD; column A is read-only to operations.
module ap_param #(
  parameter int ROWS   = 256,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input logic       clk,
  input logic       rst,
  ap_param_if.slave bus
);
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, INIT, CMP, WR, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] col_a [ROWS];
  logic [WIDTH-1:0] col_b [ROWS];
  logic [ROWS-1:0]  carry;
  logic [ROWS-1:0]  tag;
  logic [ROWS-1:0]  match;
  logic [BIT_W-1:0] bit_cnt;
  logic [1:0]       pass_cnt;
  logic [1:0]       op_r;

  // Current pass key, carry masking and write value.
  logic       key_a, key_b, key_c, use_c, wr_b, wr_c;
  logic [1:0] last_pass;

  always_comb begin
    key_a     = 1'b0;
    key_b     = 1'b0;
    key_c     = 1'b0;
    use_c     = 1'b0;
    wr_b      = 1'b0;
    wr_c      = 1'b0;
    last_pass = 2'd0;
    case (op_r)
      2'd0: begin key_a = 1'b1; key_b = 1'b0; wr_b = 1'b1; end
      2'd1: begin key_a = 1'b0; key_b = 1'b1; wr_b = 1'b0; end
      default: begin
        // Order matters: no row rewritten by one pass can satisfy a later key of the same bit.
        use_c     = 1'b1;
        last_pass = 2'd3;
        case (pass_cnt)
          2'd0:    begin key_a = 1'b0; key_b = 1'b0; key_c = 1'b1; wr_b = 1'b1; wr_c = 1'b0; end
          2'd1:    begin key_a = 1'b0; key_b = 1'b1; key_c = 1'b1; wr_b = 1'b0; wr_c = 1'b1; end
          2'd2:    begin key_a = 1'b1; key_b = 1'b1; key_c = 1'b0; wr_b = 1'b0; wr_c = 1'b1; end
          default: begin key_a = 1'b1; key_b = 1'b0; key_c = 1'b0; wr_b = 1'b1; wr_c = 1'b0; end
        endcase
      end
    endcase
  end

  always_comb begin
    match = '0;
    for (int r = 0; r < ROWS; r++) begin
      match[r] = (col_a[r][bit_cnt] == key_a) && (col_b[r][bit_cnt] == key_b) &&
                 (!use_c || (carry[r] == key_c));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bit_cnt  <= '0;
      pass_cnt <= '0;
      op_r     <= '0;
      tag      <= '0;
      carry    <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            op_r     <= bus.op;
            bus.busy <= 1'b1;
            if (bus.op == 2'd3) begin
              bus.err  <= 1'b1;
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= INIT;
            end
          end
        end
        INIT: begin
          tag      <= '0;
          carry    <= '0;
          bit_cnt  <= '0;
          pass_cnt <= '0;
          bus.err  <= 1'b0;
          state    <= CMP;
        end
        CMP: begin
          tag   <= match;
          state <= WR;
        end
        WR: begin
          for (int r = 0; r < ROWS; r++) begin
            if (tag[r] && use_c) carry[r] <= wr_c;
          end
          if (pass_cnt != last_pass) begin
            pass_cnt <= pass_cnt + 2'd1;
            state    <= CMP;
          end else if (bit_cnt != BIT_W'(WIDTH - 1)) begin
            pass_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
            state    <= CMP;
          end else begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Columns carry no reset so a mid-operation abort leaves the partial result visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == IDLE && bus.write_en) begin
        if (bus.sel_col) col_b[bus.addr] <= bus.data;
        else             col_a[bus.addr] <= bus.data;
      end else if (state == WR) begin
        for (int r = 0; r < ROWS; r++) begin
          if (tag[r]) col_b[r][bit_cnt] <= wr_b;
        end
      end
    end
  end

  assign bus.data_out  = bus.sel_col ? col_b[bus.addr] : col_a[bus.addr];
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_ap_param.sv
// Self-checking bench for ap_param (ROWS=256, WIDTH=8): expected column-B words are queued with
// their row numbers when an operation is launched and compared once done has pulsed.
module tb_ap_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] row_q[$];

  ap_param_if #(.WIDTH(8), .ADDR_W(8)) bus ();
  ap_param #(.ROWS(256), .WIDTH(8), .ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic read_word(input logic col, input logic [7:0] a, output logic [7:0] d);
    bus.sel_col = col;
    bus.addr    = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic host_write(input logic col, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.write_en = 1'b1;
    bus.sel_col  = col;
    bus.addr     = a;
    bus.data     = d;
    @(posedge clk);
    #1 bus.write_en = 1'b0;
  endtask

  // start is sampled at the following rising edge (edge 0); returns #1 after it.
  task automatic start_op(input logic [1:0] op);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts cycles after edge 0 until done; busy must stay high on the way.
  task automatic wait_done(input int cyc0, input int exp_cyc, input string name);
    int cyc = cyc0;
    bit seen = 1'b0;
    int busy_low = 0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d (seen=%0b) expected %0d", name, cyc, seen, exp_cyc);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL %s_busy: busy low in %0d cycles, expected 0", name, busy_low);
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b done=%b expected 0 0", name, bus.busy, bus.done);
    end
  endtask

  task automatic check_rows(input string name);
    logic [7:0] d, e, r;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = row_q.pop_front();
      read_word(1'b1, r, d);
      checks++;
      if (d !== e) begin
        errors++;
        $display("FAIL %s_B[%0d]: got %h expected %h", name, r, d, e);
      end
    end
  endtask

  task automatic expect_b(input logic [7:0] r, input logic [7:0] e);
    row_q.push_back(r);
    exp_q.push_back(e);
  endtask

  task automatic check_a(input logic [7:0] r, input logic [7:0] e, input string name);
    logic [7:0] d;
    read_word(1'b0, r, d);
    checks++;
    if (d !== e) begin
      errors++;
      $display("FAIL %s_A[%0d]: got %h expected %h", name, r, d, e);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b err=%b state=%0d expected 0 0 0 0",
               bus.busy, bus.done, bus.err, bus.dbg_state);
    end
    rst = 1'b0;
  endtask

  task automatic test_or;
    host_write(1'b0, 8'd0, 8'h0F);
    host_write(1'b1, 8'd0, 8'h30);
    host_write(1'b0, 8'd1, 8'h55);
    host_write(1'b1, 8'd1, 8'hA0);
    start_op(2'd0);
    expect_b(8'd0, 8'h3F);
    expect_b(8'd1, 8'hF5);
    wait_done(0, 18, "or");
    check_rows("or");
    check_a(8'd0, 8'h0F, "or");
  endtask

  task automatic test_and;
    host_write(1'b0, 8'd5, 8'hF0);
    host_write(1'b1, 8'd5, 8'h3C);
    host_write(1'b0, 8'd6, 8'hFF);
    host_write(1'b1, 8'd6, 8'h5A);
    host_write(1'b0, 8'd7, 8'hFF);
    host_write(1'b1, 8'd7, 8'hC3);
    start_op(2'd1);
    expect_b(8'd5, 8'h30);
    expect_b(8'd6, 8'h5A);
    expect_b(8'd7, 8'hC3);
    expect_b(8'd0, 8'h0F);
    wait_done(0, 18, "and");
    check_rows("and");
  endtask

  task automatic test_add;
    logic [7:0] a4, b4, a9, b9, s4, s9;
    a4 = 8'($urandom_range(0, 255));
    b4 = 8'($urandom_range(0, 255));
    a9 = 8'($urandom_range(0, 255));
    b9 = 8'($urandom_range(0, 255));
    s4 = a4 + b4;
    s9 = a9 + b9;
    host_write(1'b0, 8'd1, 8'h7F); host_write(1'b1, 8'd1, 8'h01);
    host_write(1'b0, 8'd2, 8'hFF); host_write(1'b1, 8'd2, 8'h01);
    host_write(1'b0, 8'd3, 8'h00); host_write(1'b1, 8'd3, 8'h00);
    host_write(1'b0, 8'd4, a4);    host_write(1'b1, 8'd4, b4);
    host_write(1'b0, 8'd9, a9);    host_write(1'b1, 8'd9, b9);
    start_op(2'd2);
    expect_b(8'd1, 8'h80);
    expect_b(8'd2, 8'h00);
    expect_b(8'd3, 8'h00);
    expect_b(8'd4, s4);
    expect_b(8'd9, s9);
    wait_done(0, 66, "add");
    check_rows("add");
    check_a(8'd1, 8'h7F, "add");
    check_a(8'd9, a9, "add");
  endtask

  task automatic test_err;
    start_op(2'd3);
    expect_b(8'd1, 8'h80);
    expect_b(8'd2, 8'h00);
    wait_done(0, 1, "err");
    checks++;
    if (bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_set: got %b expected 1", bus.err);
    end
    check_rows("err");
    start_op(2'd0);
    wait_done(0, 18, "err_clear");
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b expected 0", bus.err);
    end
  endtask

  task automatic test_write_busy;
    host_write(1'b0, 8'd10, 8'h01);
    host_write(1'b1, 8'd10, 8'h10);
    start_op(2'd0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL wbusy_busy: got %b expected 1", bus.busy);
    end
    bus.write_en = 1'b1;
    bus.sel_col  = 1'b1;
    bus.addr     = 8'd10;
    bus.data     = 8'hAA;
    @(posedge clk);
    #1 bus.write_en = 1'b0;
    expect_b(8'd10, 8'h11);
    wait_done(1, 18, "wbusy");
    check_rows("wbusy");
  endtask

  task automatic test_back_to_back;
    // Write and start at the same edge: the op sees B[10]=0x42.
    @(negedge clk);
    bus.write_en = 1'b1;
    bus.sel_col  = 1'b1;
    bus.addr     = 8'd10;
    bus.data     = 8'h42;
    bus.start    = 1'b1;
    bus.op       = 2'd0;
    @(posedge clk);
    #1;
    bus.write_en = 1'b0;
    bus.start    = 1'b0;
    expect_b(8'd10, 8'h43);
    wait_done(0, 18, "wr_start");
    check_rows("wr_start");
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    host_write(1'b0, 8'd8, 8'h13);
    host_write(1'b1, 8'd8, 8'h24);
    start_op(2'd2);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b done=%b state=%0d expected 0 0 0",
               bus.busy, bus.done, bus.dbg_state);
    end
    // Bits 0..2 summed (011+100=111, no carry), bit 3 untouched, upper bits original.
    read_word(1'b1, 8'd8, d);
    checks++;
    if (d !== 8'h27) begin
      errors++;
      $display("FAIL rstmid_partial: got %h expected 27", d);
    end
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.op    = 2'd0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    expect_b(8'd8, 8'h37);
    wait_done(0, 18, "rstmid_restart");
    check_rows("rstmid_restart");
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.op       = 2'd0;
    bus.write_en = 1'b0;
    bus.sel_col  = 1'b0;
    bus.addr     = '0;
    bus.data     = '0;
    test_reset();
    test_or();
    test_and();
    test_add();
    test_err();
    test_write_busy();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
